// File: rtl/fixed_weight_source_if.sv
// Weight-port bundle: tile load stream in, tile replay stream out, with the
// per-tile depth/pass flags the linear layer uses to close its accumulations.
`timescale 1ns/1ps
interface fixed_weight_source_if #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int WEIGHT_SIZE  = 8
);
    logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] load_data;
    logic                                     load_valid;
    logic                                     load_ready;
    logic                                     reload;
    logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] weight;
    logic                                     weight_valid;
    logic                                     weight_ready;
    logic                                     last_depth;
    logic                                     last_tile;

    // master: the weight source itself; slave: the loader/consumer side
    modport master (
        input  load_data, load_valid, reload, weight_ready,
        output load_ready, weight, weight_valid, last_depth, last_tile
    );
    modport slave (
        output load_data, load_valid, reload, weight_ready,
        input  load_ready, weight, weight_valid, last_depth, last_tile
    );
endinterface

// File: rtl/fixed_weight_source.sv
// Buffers one weight matrix as IN_DEPTH*OUT_DEPTH tiles and replays it forever
// at one tile per cycle. `FIXED_WEIGHT_SOURCE_PASS_COUNT_EN adds a pass counter.
`timescale 1ns/1ps
module fixed_weight_source #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int IN_SIZE      = 4,
    parameter int PARALLELISM  = 2,
    parameter int IN_DEPTH     = 3,
    parameter int OUT_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fixed_weight_source_if.master bus
`ifdef FIXED_WEIGHT_SOURCE_PASS_COUNT_EN
    ,
    output logic [15:0]           pass_count
`endif
);
    localparam int WEIGHT_SIZE = IN_SIZE * PARALLELISM;
    localparam int TILES       = IN_DEPTH * OUT_DEPTH;
    localparam int PTR_W       = $clog2(TILES) + 1;
    localparam int DEPTH_W     = $clog2(IN_DEPTH) + 1;
    localparam int OUT_W       = $clog2(OUT_DEPTH) + 1;
    localparam int ADDR_W      = (TILES > 1) ? $clog2(TILES) : 1;

    localparam logic [PTR_W-1:0]   LAST_TILE_PTR = PTR_W'(TILES - 1);
    localparam logic [DEPTH_W-1:0] LAST_DEPTH    = DEPTH_W'(IN_DEPTH - 1);
    localparam logic [OUT_W-1:0]   LAST_OUT      = OUT_W'(OUT_DEPTH - 1);

    typedef logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] tile_t;
    typedef enum logic {LOAD, STREAM} state_t;

    state_t              state, next_state;
    tile_t               tile_buf [TILES];
    tile_t               weight_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [DEPTH_W-1:0]  depth_idx, nxt_depth;
    logic [OUT_W-1:0]    out_idx, nxt_out;
    logic [ADDR_W-1:0]   rd_addr;
    logic                reload_pend;
    logic                load_fire, weight_fire, reload_go, last_write;

    assign bus.load_ready   = (state == LOAD) && rst;
    assign bus.weight_valid = (state == STREAM);
    assign bus.weight       = weight_q;
    assign bus.last_depth   = (depth_idx == LAST_DEPTH) && bus.weight_valid;
    assign bus.last_tile    = bus.last_depth && (out_idx == LAST_OUT);

    assign load_fire   = bus.load_valid && bus.load_ready;
    assign weight_fire = bus.weight_valid && bus.weight_ready;
    assign reload_go   = weight_fire && (reload_pend || bus.reload);
    assign last_write  = load_fire && (wr_ptr == LAST_TILE_PTR);

    // Index of the tile that follows the one currently presented.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_depth = depth_idx + DEPTH_W'(1);
        nxt_out   = out_idx;
        if (depth_idx == LAST_DEPTH) begin
            nxt_depth = '0;
            nxt_out   = (out_idx == LAST_OUT) ? '0 : out_idx + OUT_W'(1);
        end
        rd_addr = ADDR_W'(int'(nxt_out) * IN_DEPTH + int'(nxt_depth));
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (last_write) next_state = STREAM;
            STREAM:  if (reload_go)  next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= next_state;
    end

    // NOTE: the tile buffer has no reset; a reset forces a full reload before it is read again.
    always_ff @(posedge clk) begin
        if (load_fire) tile_buf[wr_ptr[ADDR_W-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            depth_idx   <= '0;
            out_idx     <= '0;
            reload_pend <= 1'b0;
            weight_q    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (last_write) begin
                        wr_ptr <= '0;
                        // A single-tile matrix must see the tile written on this very edge.
                        if (TILES == 1) weight_q <= bus.load_data;
                        else            weight_q <= tile_buf[0];
                    end else if (load_fire) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                end
                STREAM: begin
                    if (bus.reload) reload_pend <= 1'b1;
                    if (reload_go) begin
                        wr_ptr      <= '0;
                        depth_idx   <= '0;
                        out_idx     <= '0;
                        reload_pend <= 1'b0;
                    end else if (weight_fire) begin
                        depth_idx <= nxt_depth;
                        out_idx   <= nxt_out;
                        weight_q  <= tile_buf[rd_addr];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIXED_WEIGHT_SOURCE_PASS_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               pass_count <= '0;
        else if (reload_go)                     pass_count <= '0;
        else if (weight_fire && bus.last_tile)  pass_count <= pass_count + 16'd1;
    end
`endif

endmodule

// File: doc/fixed_weight_source.md
Name: fixed_weight_source

Overview:
- Transmitter side of the linear-layer weight port.
- Holds one full weight matrix as IN_DEPTH*OUT_DEPTH tiles in a register-array buffer. Each tile is WEIGHT_SIZE = IN_SIZE*PARALLELISM words.
- Filled once over a load stream, then replays tiles in order over a valid/ready weight stream, indefinitely, with zero bubbles.
- Sits between the weight loader (DMA/ROM) and the weight input of the fixed linear layer.

Parameters:
- WEIGHT_WIDTH, 16, bits per weight word.
- IN_SIZE, 4, words per input-side tile row.
- PARALLELISM, 2, output lanes per tile; WEIGHT_SIZE = IN_SIZE*PARALLELISM.
- IN_DEPTH, 3, tiles per output group (beats accumulated by the consumer).
- OUT_DEPTH, 2, output groups per pass; TILES = IN_DEPTH*OUT_DEPTH.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, reset: asynchronous, active-low (0 = reset).
- load_data, input, [WEIGHT_WIDTH-1:0] x [WEIGHT_SIZE-1:0], one tile being loaded.
- load_valid, input, 1, load tile valid.
- load_ready, output, 1, buffer accepts a tile.
- reload, input, 1, request to return to LOAD for a new matrix.
- weight, output, [WEIGHT_WIDTH-1:0] x [WEIGHT_SIZE-1:0], current tile.
- weight_valid, output, 1, tile valid.
- weight_ready, input, 1, consumer accepts the tile.
- last_depth, output, 1, current tile has depth_idx == IN_DEPTH-1.
- last_tile, output, 1, current tile is address TILES-1.

Behaviour:
- Reset (rst=0, async): state=LOAD; wr_ptr=0, depth_idx=0, out_idx=0; reload_pend=0.
- Reset output values: weight_valid=0, load_ready=0 while rst low, weight=all zeros, last_depth=0, last_tile=0.
- Reset mid-operation discards the buffer contents (re-load required); buffer contents are not cleared.
- States: LOAD, STREAM.
- LOAD:
  - load_ready=1, weight_valid=0.
  - On load_valid&&load_ready: write tile to buf[wr_ptr], wr_ptr++.
  - On the write with wr_ptr==TILES-1: wr_ptr->0 and go to STREAM.
  - On that same edge, the output register loads buf[0]; the newly written tile is forwarded if TILES==1.
- STREAM:
  - load_ready=0; load_valid is ignored.
  - The output register holds buf[out_idx*IN_DEPTH+depth_idx].
  - weight_valid=1 from the first cycle in STREAM: 1 cycle after the final load handshake.
- Handshake (weight_valid&&weight_ready):
  - depth_idx++; at IN_DEPTH-1 it wraps to 0 and out_idx++.
  - out_idx wraps at OUT_DEPTH-1 to 0, then the pass restarts at tile 0.
  - The next tile is read combinationally and registered on the same edge, so back-to-back handshakes give 1 tile/cycle.
- Backpressure: while weight_valid&&!weight_ready, weight, last_depth and last_tile stay stable and the indices hold.
- reload:
  - Sampled in STREAM, it sets reload_pend.
  - On the next handshake with reload_pend (or reload) high: go to LOAD, clear indices and wr_ptr, clear reload_pend; weight_valid=0 the following cycle.
  - weight_valid never drops without a completed handshake.
  - reload in LOAD is ignored.
- Flags:
  - last_depth = (depth_idx==IN_DEPTH-1) && weight_valid.
  - last_tile = last_depth && (out_idx==OUT_DEPTH-1).
- Widths: pointers are $clog2(TILES)+1 bits; indices are $clog2(depth)+1 bits. No arithmetic on data; words pass unchanged.

Optional Feature:
- Macro: FIXED_WEIGHT_SOURCE_PASS_COUNT_EN.
- Defined:
  - Adds output pass_count [15:0], reset 0.
  - Increments on each handshake of the last_tile tile; wraps 0xFFFF->0.
  - Cleared on entry to LOAD.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults: load 6 tiles with word k of tile t = 16*t+k, weight_ready=1 -> weight_valid rises 1 cycle after 6th load; tiles 0,1,2,3,4,5,0,1 on consecutive cycles; last_depth on tiles 2,5; last_tile on 5.
- Backpressure: weight_ready=0 for 4 cycles on tile 3 -> weight holds tile 3 (first word 48) stable, valid stays 1; tile 4 follows on first ready cycle.
- Reload: pulse reload with ready=0 at tile 1, then ready=1 -> tile 1 accepted, weight_valid=0 next cycle, load_ready=1; new load of 6 tiles (value 0xA000+k) streams the new tiles from tile 0.
- Load gating: load_valid=1 during STREAM with junk data -> load_ready=0, stream contents unchanged across 2 full passes.
- Async reset: drive rst=0 mid-edge during STREAM at tile 4 -> weight_valid=0 immediately (no clock), load_ready=1 after release; stream restarts from tile 0 after a full reload.
- With FIXED_WEIGHT_SOURCE_PASS_COUNT_EN: run 3 full passes -> pass_count=3; reload -> pass_count=0.
